// File: rtl/ucsbece154b_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module : ucsbece154b_fetch_unit_pkg
//  Brief  : Shared types and constants for the instruction-fetch stage.
//  Rev    : 1.0  initial release
// ============================================================================
package ucsbece154b_fetch_unit_pkg;

  // Fetch-side request tracking: live request, word parked in buffer,
  // or a stale request whose response must be thrown away.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_BUF  = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0001_0000;

endpackage
`default_nettype wire

// File: rtl/ucsbece154b_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module : ucsbece154b_fetch_unit
//  Brief  : IF stage. Owns PCF and the IF/ID register, drives a single-
//           outstanding variable-latency instruction memory port, and fills
//           decode with bubbles while memory is slow.
//  Rev    : 1.0  initial release
// ============================================================================
module ucsbece154b_fetch_unit
  import ucsbece154b_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD_i,
  input  logic        FlushD_i,
  input  logic        PCSrcE_i,
  input  logic [31:0] PCTargetE_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] PCF_o,
  output logic [31:0] InstrD_o,
  output logic [31:0] PCD_o,
  output logic [31:0] PCPlus4D_o,
  output logic        ValidD_o
);

  fetch_state_t state, state_n;
  logic [31:0]  pcf, pcf_n;
  logic [31:0]  buffer, buffer_n;
  logic [31:0]  drop_addr, drop_addr_n;
  logic [31:0]  fetch_addr;
  logic [31:0]  pcf_plus4;
  logic [31:0]  word;
  logic         word_avail;
  logic         consume;

  // Memory port is decoded from registered state only; the stale address is
  // held while a discarded request is still in flight.
  assign fetch_addr  = (state == S_DROP) ? drop_addr : pcf;
  assign imem_addr_o = fetch_addr;
  assign imem_req_o  = !reset && (state != S_BUF);
  assign PCF_o       = pcf;

  assign pcf_plus4  = pcf + 32'd4;
  assign word_avail = ((state == S_REQ) && imem_ready_i) || (state == S_BUF);
  assign word       = (state == S_BUF) ? buffer : imem_rdata_i;
  assign consume    = word_avail && !PCSrcE_i && !FlushD_i && !StallD_i;

  // Next-state: redirect beats everything, then consume, then park/drop.
  always_comb begin
    state_n     = state;
    pcf_n       = pcf;
    buffer_n    = buffer;
    drop_addr_n = drop_addr;
    if (PCSrcE_i) begin
      pcf_n = PCTargetE_i;
      if (((state == S_REQ) || (state == S_DROP)) && !imem_ready_i) begin
        drop_addr_n = fetch_addr;
        state_n     = S_DROP;
      end else begin
        state_n = S_REQ;
      end
    end else if (consume) begin
      pcf_n   = pcf_plus4;
      state_n = S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          // Word arrived but decode cannot take it: park it.
          if (imem_ready_i) begin
            buffer_n = imem_rdata_i;
            state_n  = S_BUF;
          end
        end
        S_DROP: begin
          if (imem_ready_i) state_n = S_REQ;
        end
        default: begin
          state_n = state;
        end
      endcase
    end
  end

  // Fetch state, PC, holding buffer and stale-request address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_REQ;
      pcf       <= RESET_PC;
      buffer    <= NOP_INSTR;
      drop_addr <= 32'd0;
    end else begin
      state     <= state_n;
      pcf       <= pcf_n;
      buffer    <= buffer_n;
      drop_addr <= drop_addr_n;
    end
  end

  // IF/ID register: flush/redirect bubble, stall hold, load or bubble.
  always_ff @(posedge clk) begin
    if (reset || PCSrcE_i || FlushD_i) begin
      InstrD_o   <= NOP_INSTR;
      PCD_o      <= 32'd0;
      PCPlus4D_o <= 32'd0;
      ValidD_o   <= 1'b0;
    end else if (StallD_i) begin
      InstrD_o   <= InstrD_o;
      PCD_o      <= PCD_o;
      PCPlus4D_o <= PCPlus4D_o;
      ValidD_o   <= ValidD_o;
    end else if (consume) begin
      InstrD_o   <= word;
      PCD_o      <= pcf;
      PCPlus4D_o <= pcf_plus4;
      ValidD_o   <= 1'b1;
    end else begin
      InstrD_o   <= NOP_INSTR;
      PCD_o      <= 32'd0;
      PCPlus4D_o <= 32'd0;
      ValidD_o   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module : tb_ucsbece154b_fetch_unit
//  Brief  : Self-checking bench for the fetch stage: latency-programmable
//           memory model plus a queue of expected IF/ID entries.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_ucsbece154b_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallD_i = 1'b0;
  logic        FlushD_i = 1'b0;
  logic        PCSrcE_i = 1'b0;
  logic [31:0] PCTargetE_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic [31:0] PCF_o;
  logic [31:0] InstrD_o;
  logic [31:0] PCD_o;
  logic [31:0] PCPlus4D_o;
  logic        ValidD_o;

  ucsbece154b_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .StallD_i     (StallD_i),
    .FlushD_i     (FlushD_i),
    .PCSrcE_i     (PCSrcE_i),
    .PCTargetE_i  (PCTargetE_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_rdata_i (imem_rdata_i),
    .PCF_o        (PCF_o),
    .InstrD_o     (InstrD_o),
    .PCD_o        (PCD_o),
    .PCPlus4D_o   (PCPlus4D_o),
    .ValidD_o     (ValidD_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 0;
  int          mem_cnt = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_pc = 32'd0;

  // Memory contents: distinct from the address so PC/instruction swaps show.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare the IF/ID contents against the scoreboard.
  task automatic monitor(input logic held);
    logic [31:0] pc;
    if (ValidD_o) begin
      if (held) begin
        check("hold_instr", InstrD_o, mem_word(last_pc));
        check("hold_pc", PCD_o, last_pc);
      end else if (sb_q.size() == 0) begin
        check("unexpected_valid", {31'd0, ValidD_o}, 32'd0);
      end else begin
        pc = sb_q.pop_front();
        last_pc = pc;
        check("instr", InstrD_o, mem_word(pc));
        check("pcd", PCD_o, pc);
        check("pcplus4", PCPlus4D_o, pc + 32'd4);
      end
    end else begin
      check("bubble_instr", InstrD_o, NOP);
      check("bubble_pcd", PCD_o, 32'd0);
    end
  endtask

  // One clock: memory model drives the response, edge, then checks.
  task automatic tick();
    logic        req_now;
    logic [31:0] addr_now;
    logic        held;
    logic        rst_edge;
    req_now  = imem_req_o;
    addr_now = imem_addr_o;
    if (req_now && mem_cnt >= mem_lat) begin
      imem_ready_i = 1'b1;
      imem_rdata_i = mem_word(addr_now);
    end else begin
      imem_ready_i = 1'b0;
      imem_rdata_i = 32'hDEAD_BEEF;
    end
    held     = StallD_i && !FlushD_i && !PCSrcE_i;
    rst_edge = reset;
    @(posedge clk);
    #1;
    if (rst_edge) begin
      mem_cnt = 0;
    end else begin
      if (req_now) mem_cnt = imem_ready_i ? 0 : mem_cnt + 1;
      if (req_now && !imem_ready_i) begin
        check("req_held", {31'd0, imem_req_o}, 32'd1);
        check("addr_stable", imem_addr_o, addr_now);
      end
      monitor(held);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset values.
    #1;
    tick();
    tick();
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_pcf", PCF_o, 32'h0001_0000);
    check("rst_instr", InstrD_o, NOP);
    check("rst_pcd", PCD_o, 32'd0);
    check("rst_pc4", PCPlus4D_o, 32'd0);
    check("rst_valid", {31'd0, ValidD_o}, 32'd0);

    // Zero-wait memory: one instruction per cycle.
    reset = 1'b0;
    #1;
    check("req_after_rst", {31'd0, imem_req_o}, 32'd1);
    check("addr_after_rst", imem_addr_o, 32'h0001_0000);
    mem_lat = 0;
    for (int i = 0; i < 3; i++) sb_q.push_back(32'h0001_0000 + 32'(4 * i));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("zw_valid", {31'd0, ValidD_o}, 32'd1);
    end
    check("zw_pcf", PCF_o, 32'h0001_000C);

    // Ready every third cycle: two bubbles per instruction.
    mem_lat = 2;
    for (int i = 0; i < 3; i++) sb_q.push_back(32'h0001_000C + 32'(4 * i));
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("slow_valid", {31'd0, ValidD_o}, (i % 3 == 0) ? 32'd1 : 32'd0);
      check("slow_pcf", PCF_o, 32'h0001_000C + 32'(4 * (i / 3)));
    end

    // Stall while the next word returns: parked, then delivered once.
    mem_lat = 0;
    StallD_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_req", {31'd0, imem_req_o}, 32'd0);
      check("stall_pcf", PCF_o, 32'h0001_0018);
    end
    StallD_i = 1'b0;
    sb_q.push_back(32'h0001_0018);
    sb_q.push_back(32'h0001_001C);
    tick();
    check("unstall_valid", {31'd0, ValidD_o}, 32'd1);
    check("unstall_addr", imem_addr_o, 32'h0001_001C);
    tick();

    // Redirect with a request in flight: stale word dropped.
    mem_lat = 3;
    tick();
    PCSrcE_i = 1'b1;
    PCTargetE_i = 32'h0001_0100;
    tick();
    PCSrcE_i = 1'b0;
    check("drop_addr", imem_addr_o, 32'h0001_0020);
    check("drop_pcf", PCF_o, 32'h0001_0100);
    tick();
    tick();
    check("after_drop_addr", imem_addr_o, 32'h0001_0100);
    check("after_drop_valid", {31'd0, ValidD_o}, 32'd0);
    mem_lat = 0;
    sb_q.push_back(32'h0001_0100);
    tick();

    // Redirect + flush + stall together with a ready word.
    PCSrcE_i = 1'b1;
    FlushD_i = 1'b1;
    StallD_i = 1'b1;
    PCTargetE_i = 32'h0002_0000;
    tick();
    PCSrcE_i = 1'b0;
    FlushD_i = 1'b0;
    StallD_i = 1'b0;
    check("combo_valid", {31'd0, ValidD_o}, 32'd0);
    check("combo_pcf", PCF_o, 32'h0002_0000);
    check("combo_addr", imem_addr_o, 32'h0002_0000);
    sb_q.push_back(32'h0002_0000);
    tick();

    // Flush alone parks the returning word; it is consumed next.
    FlushD_i = 1'b1;
    tick();
    FlushD_i = 1'b0;
    check("flush_valid", {31'd0, ValidD_o}, 32'd0);
    sb_q.push_back(32'h0002_0004);
    tick();

    // PC wrap at the top of the address space.
    PCSrcE_i = 1'b1;
    PCTargetE_i = 32'hFFFF_FFFC;
    tick();
    PCSrcE_i = 1'b0;
    sb_q.push_back(32'hFFFF_FFFC);
    sb_q.push_back(32'h0000_0000);
    tick();
    check("wrap_pc4", PCPlus4D_o, 32'd0);
    check("wrap_pcf", PCF_o, 32'd0);
    tick();

    // Reset while a stale request is outstanding.
    mem_lat = 3;
    tick();
    PCSrcE_i = 1'b1;
    PCTargetE_i = 32'h0003_0000;
    tick();
    PCSrcE_i = 1'b0;
    check("pre_rst_drop_addr", imem_addr_o, 32'h0000_0004);
    reset = 1'b1;
    #1;
    tick();
    check("rst2_pcf", PCF_o, 32'h0001_0000);
    check("rst2_req", {31'd0, imem_req_o}, 32'd0);
    check("rst2_valid", {31'd0, ValidD_o}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst2_addr", imem_addr_o, 32'h0001_0000);
    check("rst2_req_rel", {31'd0, imem_req_o}, 32'd1);
    mem_lat = 0;
    sb_q.push_back(32'h0001_0000);
    tick();
    check("rst2_first_valid", {31'd0, ValidD_o}, 32'd1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
